// File: rtl/time_pkg.sv
// Shared types, BCD limits and payload validation for the BCD time-of-day counter.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package time_pkg;

  typedef enum logic [1:0] {
    S_STOP = 2'd0,
    S_RUN  = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  localparam logic [3:0] SEC_T_MAX = 4'd5;
  localparam logic [3:0] DIG_MAX   = 4'd9;
  localparam logic [7:0] H24_MAX   = 8'h23;
  localparam logic [7:0] H12_MIN   = 8'h01;
  localparam logic [7:0] H12_MAX   = 8'h12;
  // Last 12h hour before noon/midnight; stepping past it flips AM/PM.
  localparam logic [7:0] H12_FLIP  = 8'h11;

  // Nibble offsets inside the {Ht,Ho,Mt,Mo,St,So} word.
  localparam int SO_LSB = 0;
  localparam int ST_LSB = 4;
  localparam int MO_LSB = 8;
  localparam int MT_LSB = 12;
  localparam int HO_LSB = 16;
  localparam int HT_LSB = 20;

  // A time word is acceptable when every digit is in range and the hour
  // pair is legal for the active hour mode (24h: 00..23, 12h: 01..12).
  function automatic logic bcd_ok(input logic [23:0] t, input logic mode12);
    logic [7:0] h;
    logic       dig_ok;
    h      = t[HO_LSB +: 8];
    dig_ok = (t[SO_LSB +: 4] <= DIG_MAX) && (t[ST_LSB +: 4] <= SEC_T_MAX) &&
             (t[MO_LSB +: 4] <= DIG_MAX) && (t[MT_LSB +: 4] <= SEC_T_MAX) &&
             (t[HO_LSB +: 4] <= DIG_MAX) && (t[HT_LSB +: 4] <= DIG_MAX);
    if (mode12) begin
      return dig_ok && (h >= H12_MIN) && (h <= H12_MAX);
    end
    return dig_ok && (h <= H24_MAX);
  endfunction

endpackage

// File: rtl/bcd_time_counter_if.sv
// Control/load/time bundle between front panel (master) and time counter (slave).
// Latency: wires only. Optional alarm signals exist when ALARM_EN is defined.
// Backpressure: load_valid is accepted only while load_ready is high.
interface bcd_time_counter_if;
  logic        run;
  logic        hour_mode;
  logic        load_valid;
  logic [23:0] load_bcd;
  logic        load_pm;
  logic        load_ready;
  logic        load_err;
  logic [23:0] time_bcd;
  logic        pm;
  logic        sec_tick;
  logic        day_wrap;
  logic        running;
`ifdef ALARM_EN
  logic        alarm_valid;
  logic [23:0] alarm_bcd;
  logic        alarm_pm;
  logic        alarm_arm;
  logic        alarm_hit;

  modport master (
    output run, hour_mode, load_valid, load_bcd, load_pm,
           alarm_valid, alarm_bcd, alarm_pm, alarm_arm,
    input  load_ready, load_err, time_bcd, pm, sec_tick, day_wrap, running, alarm_hit
  );
  modport slave (
    input  run, hour_mode, load_valid, load_bcd, load_pm,
           alarm_valid, alarm_bcd, alarm_pm, alarm_arm,
    output load_ready, load_err, time_bcd, pm, sec_tick, day_wrap, running, alarm_hit
  );
`else
  modport master (
    output run, hour_mode, load_valid, load_bcd, load_pm,
    input  load_ready, load_err, time_bcd, pm, sec_tick, day_wrap, running
  );
  modport slave (
    input  run, hour_mode, load_valid, load_bcd, load_pm,
    output load_ready, load_err, time_bcd, pm, sec_tick, day_wrap, running
  );
`endif
endinterface

// File: rtl/bcd_digit.sv
// Single BCD digit counting 0..MAX with synchronous load; load has priority over inc.
// Latency: value updates on the clock edge after inc/load; carry is combinational.
// Backpressure: none, the digit always accepts inc/load.
module bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] value,
  output logic       carry
);

  logic [3:0] r_val;

  // Digit register: load wins, otherwise wrap to 0 after MAX on inc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val <= 4'd0;
    end else if (load) begin
      r_val <= load_val;
    end else if (inc) begin
      r_val <= (r_val == MAX) ? 4'd0 : r_val + 4'd1;
    end
  end

  assign value = r_val;
  assign carry = inc & (r_val == MAX);

endmodule

// File: rtl/bcd_time_counter.sv
// HH:MM:SS BCD time-of-day counter with 12h/24h wrap, 1 s prescaler and validated load.
// Latency: time moves on the sec_tick edge; load applies 1 cycle after handshake. ALARM_EN adds alarm.
// Backpressure: load_ready drops for the single S_LOAD cycle and while rst is high.
module bcd_time_counter
  import time_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int PRE_W    = 26
) (
  input  logic               clk,
  input  logic               rst,
  bcd_time_counter_if.slave  bus
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  state_t           r_state, w_state_nxt;
  logic             r_mode;
  logic [PRE_W-1:0] r_pre;
  logic [23:0]      r_ld_bcd;
  logic             r_ld_pm;
  logic [7:0]       r_hour;
  logic             r_pm;

  logic [3:0]  w_so, w_st, w_mo, w_mt;
  logic        w_c_so, w_c_st, w_c_mo, w_c_mt;
  logic        w_hs, w_tick, w_mode_chg, w_ld_ok, w_do_load, w_dig_load, w_ld_err;
  logic [23:0] w_dig_src, w_time;
  logic [7:0]  w_hour_inc, w_hour_nxt;
  logic        w_pm_tgl;

  assign w_hs       = bus.load_valid & bus.load_ready;
  // A load handshake in the prescaler's last cycle suppresses that tick.
  assign w_tick     = (r_state == S_RUN) & (r_pre == PRE_MAX) & ~w_hs;
  assign w_mode_chg = (r_state == S_STOP) & (bus.hour_mode != r_mode);
  assign w_ld_ok    = bcd_ok(r_ld_bcd, r_mode);
  assign w_do_load  = (r_state == S_LOAD) & w_ld_ok;
  assign w_ld_err   = (r_state == S_LOAD) & ~w_ld_ok;
  // Mode change forces midnight, which is all-zero for the minute/second digits.
  assign w_dig_load = w_do_load | w_mode_chg;
  assign w_dig_src  = w_mode_chg ? 24'h000000 : r_ld_bcd;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_STOP;
    else     r_state <= w_state_nxt;
  end

  // FSM next state; a load handshake takes priority over run/stop.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_STOP:  if (w_hs) w_state_nxt = S_LOAD; else if (bus.run)  w_state_nxt = S_RUN;
      S_RUN:   if (w_hs) w_state_nxt = S_LOAD; else if (!bus.run) w_state_nxt = S_STOP;
      S_LOAD:  w_state_nxt = bus.run ? S_RUN : S_STOP;
      default: w_state_nxt = S_STOP;
    endcase
  end

  // Prescaler runs only in S_RUN; it is zero whenever we are stopped or loading.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else if ((r_state == S_RUN) && !w_hs) begin
      r_pre <= (r_pre == PRE_MAX) ? '0 : r_pre + PRE_W'(1);
    end else begin
      r_pre <= '0;
    end
  end

  // Capture the payload on the handshake edge so later bus changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_bcd <= 24'h000000;
      r_ld_pm  <= 1'b0;
    end else if (w_hs) begin
      r_ld_bcd <= bus.load_bcd;
      r_ld_pm  <= bus.load_pm;
    end
  end

  bcd_digit #(.MAX(DIG_MAX)) u_so (
    .clk(clk), .rst(rst), .inc(w_tick), .load(w_dig_load),
    .load_val(w_dig_src[SO_LSB +: 4]), .value(w_so), .carry(w_c_so));
  bcd_digit #(.MAX(SEC_T_MAX)) u_st (
    .clk(clk), .rst(rst), .inc(w_c_so), .load(w_dig_load),
    .load_val(w_dig_src[ST_LSB +: 4]), .value(w_st), .carry(w_c_st));
  bcd_digit #(.MAX(DIG_MAX)) u_mo (
    .clk(clk), .rst(rst), .inc(w_c_st), .load(w_dig_load),
    .load_val(w_dig_src[MO_LSB +: 4]), .value(w_mo), .carry(w_c_mo));
  bcd_digit #(.MAX(SEC_T_MAX)) u_mt (
    .clk(clk), .rst(rst), .inc(w_c_mo), .load(w_dig_load),
    .load_val(w_dig_src[MT_LSB +: 4]), .value(w_mt), .carry(w_c_mt));

  assign w_hour_inc = (r_hour[3:0] == DIG_MAX) ? {r_hour[7:4] + 4'd1, 4'd0}
                                               : {r_hour[7:4], r_hour[3:0] + 4'd1};

  // Next hour on an hour carry: 24h wraps 23->00; 12h goes 12->01 and 11->12 with AM/PM flip.
  always_comb begin
    w_hour_nxt = w_hour_inc;
    w_pm_tgl   = 1'b0;
    if (r_mode) begin
      if (r_hour == H12_MAX) begin
        w_hour_nxt = H12_MIN;
      end else if (r_hour == H12_FLIP) begin
        w_hour_nxt = H12_MAX;
        w_pm_tgl   = 1'b1;
      end
    end else if (r_hour == H24_MAX) begin
      w_hour_nxt = 8'h00;
    end
  end

  // Hour pair, PM flag and sampled hour mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= 1'b0;
      r_hour <= 8'h00;
      r_pm   <= 1'b0;
    end else if (w_mode_chg) begin
      r_mode <= bus.hour_mode;
      r_hour <= bus.hour_mode ? H12_MAX : 8'h00;
      r_pm   <= 1'b0;
    end else if (w_do_load) begin
      r_hour <= r_ld_bcd[HO_LSB +: 8];
      r_pm   <= r_mode & r_ld_pm;
    end else if (w_c_mt) begin
      r_hour <= w_hour_nxt;
      r_pm   <= r_pm ^ w_pm_tgl;
    end
  end

  assign w_time          = {r_hour, w_mt, w_mo, w_st, w_so};
  assign bus.time_bcd    = w_time;
  assign bus.pm          = r_pm;
  assign bus.sec_tick    = w_tick;
  assign bus.running     = (r_state == S_RUN);
  assign bus.load_ready  = ~rst & (r_state != S_LOAD);
  assign bus.day_wrap    = w_c_mt & (r_mode ? ((r_hour == H12_FLIP) & r_pm) : (r_hour == H24_MAX));

`ifdef ALARM_EN
  logic [23:0] r_alm;
  logic        r_alm_pm;
  logic        r_ticked;
  logic        w_alm_err;

  assign w_alm_err = bus.alarm_valid & ~bcd_ok(bus.alarm_bcd, r_mode);

  // Alarm time register and a one-cycle delayed tick so only counting (not loads) can fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alm    <= 24'h000000;
      r_alm_pm <= 1'b0;
      r_ticked <= 1'b0;
    end else begin
      r_ticked <= w_tick;
      if (bus.alarm_valid && !w_alm_err) begin
        r_alm    <= bus.alarm_bcd;
        r_alm_pm <= r_mode & bus.alarm_pm;
      end
    end
  end

  assign bus.alarm_hit = r_ticked & bus.alarm_arm & (w_time == r_alm) & (r_pm == r_alm_pm);
  assign bus.load_err  = w_ld_err | w_alm_err;
`else
  assign bus.load_err  = w_ld_err;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Self-checking bench for bcd_time_counter with TICK_DIV=4.
// Load results are checked through an expected-value queue popped when the load completes.
// Tick timing, wrap and reset cases are hand-written sequences.
module tb_bcd_time_counter;
  import time_pkg::*;

  localparam int TD = 4;

  logic clk;
  logic rst;
  bcd_time_counter_if bus();

  bcd_time_counter #(.TICK_DIV(TD), .PRE_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [23:0] t;
    logic        pm;
  } exp_t;

  typedef struct {
    logic        mode;
    logic [23:0] bcd;
    logic        lpm;
    logic        err;
    logic [23:0] t;
    logic        pm;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_x;
  vec_t tbl[12];
  int   checks = 0;
  int   errors = 0;
  logic in_load = 1'b0;
  logic err_seen = 1'b0;

  function automatic void chk1(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin errors++; $display("FAIL %s: got %b want %b", nm, a, e); end
  endfunction

  function automatic void chk24(input string nm, input logic [23:0] a, input logic [23:0] e);
    checks++;
    if (a !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, a, e); end
  endfunction

  function automatic void chki(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin errors++; $display("FAIL %s: got %0d want %0d", nm, a, e); end
  endfunction

  // Load monitor: pops an expectation after each S_LOAD cycle; load_err outside S_LOAD is an error.
  always @(negedge clk) begin
    if (rst) begin
      in_load = 1'b0;
    end else begin
      if (in_load) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow: got load with no expectation want queued entry");
        end else begin
          mon_x = sbq.pop_front();
          chk1("load_err", err_seen, mon_x.err);
          chk24("load_time", bus.time_bcd, mon_x.t);
          chk1("load_pm", bus.pm, mon_x.pm);
        end
      end
      if (bus.load_ready && bus.load_err) begin
        checks++; errors++;
        $display("FAIL stray_load_err: got 1 want 0 outside S_LOAD");
      end
      in_load  = !bus.load_ready;
      err_seen = bus.load_err;
    end
  end

`ifdef ALARM_EN
  int alarm_hits = 0;
  always @(negedge clk) if (!rst && bus.alarm_hit) alarm_hits++;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic apply_reset();
    rst = 1'b1;
    bus.run = 1'b0; bus.hour_mode = 1'b0; bus.load_valid = 1'b0;
    bus.load_bcd = 24'h000000; bus.load_pm = 1'b0;
`ifdef ALARM_EN
    bus.alarm_valid = 1'b0; bus.alarm_bcd = 24'h000000; bus.alarm_pm = 1'b0; bus.alarm_arm = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sbq.delete();
  endtask

  task automatic do_load(input logic [23:0] bcd, input logic lpm,
                         input logic e_err, input logic [23:0] e_t, input logic e_pm);
    exp_t x;
    @(posedge clk); #1;
    bus.load_valid = 1'b1; bus.load_bcd = bcd; bus.load_pm = lpm;
    x.err = e_err; x.t = e_t; x.pm = e_pm;
    sbq.push_back(x);
    @(posedge clk); #1;
    bus.load_valid = 1'b0; bus.load_bcd = ~bcd; bus.load_pm = ~lpm;
    repeat (2) @(posedge clk);
  endtask

  task automatic set_mode(input logic m);
    @(posedge clk); #1 bus.hour_mode = m;
    @(posedge clk);
    @(negedge clk);
    chk24("mode_midnight_time", bus.time_bcd, m ? 24'h120000 : 24'h000000);
    chk1("mode_midnight_pm", bus.pm, 1'b0);
  endtask

  // Run until n ticks are seen (bounded), then stop; counts day_wrap pulses.
  task automatic tick_run(input int n, output int wraps, output int wrap_at);
    int seen;
    seen = 0; wraps = 0; wrap_at = -1;
    @(posedge clk); #1 bus.run = 1'b1;
    for (int c = 0; c < n * TD + 8 && seen < n; c++) begin
      @(negedge clk);
      if (bus.sec_tick) seen++;
      if (bus.day_wrap) begin wraps++; wrap_at = bus.sec_tick ? seen : -1; end
    end
    chki("tick_count", seen, n);
    @(posedge clk); #1 bus.run = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  int ticks, wraps, wrap_at, found;

  initial begin
    tbl[0]  = '{1'b1, 24'h000000, 1'b0, 1'b1, 24'h120000, 1'b0};
    tbl[1]  = '{1'b1, 24'h130000, 1'b0, 1'b1, 24'h120000, 1'b0};
    tbl[2]  = '{1'b1, 24'h073015, 1'b1, 1'b0, 24'h073015, 1'b1};
    tbl[3]  = '{1'b1, 24'h0A0000, 1'b0, 1'b1, 24'h073015, 1'b1};
    tbl[4]  = '{1'b1, 24'h126000, 1'b0, 1'b1, 24'h073015, 1'b1};
    tbl[5]  = '{1'b1, 24'h120000, 1'b1, 1'b0, 24'h120000, 1'b1};
    tbl[6]  = '{1'b0, 24'h246000, 1'b0, 1'b1, 24'h000000, 1'b0};
    tbl[7]  = '{1'b0, 24'h235960, 1'b0, 1'b1, 24'h000000, 1'b0};
    tbl[8]  = '{1'b0, 24'h23595A, 1'b0, 1'b1, 24'h000000, 1'b0};
    tbl[9]  = '{1'b0, 24'h195959, 1'b1, 1'b0, 24'h195959, 1'b0};
    tbl[10] = '{1'b0, 24'h240000, 1'b0, 1'b1, 24'h195959, 1'b0};
    tbl[11] = '{1'b0, 24'h000000, 1'b0, 1'b0, 24'h000000, 1'b0};

    rst = 1'b1;
    apply_reset();
    rst = 1'b1;
    @(negedge clk);
    chk24("rst_time", bus.time_bcd, 24'h000000);
    chk1("rst_pm", bus.pm, 1'b0);
    chk1("rst_ready", bus.load_ready, 1'b0);
    chk1("rst_running", bus.running, 1'b0);
    chk1("rst_tick", bus.sec_tick, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk1("ready_after_rst", bus.load_ready, 1'b1);

    // 60 seconds of 24h counting with a tick every 4th cycle.
    @(posedge clk); #1 bus.run = 1'b1;
    @(posedge clk);
    ticks = 0; wraps = 0;
    for (int k = 0; k < 60 * TD; k++) begin
      @(negedge clk);
      chk1("tick_phase", bus.sec_tick, (k % TD) == (TD - 1));
      if (bus.sec_tick) ticks++;
      if (bus.day_wrap) wraps++;
    end
    chk1("running", bus.running, 1'b1);
    @(posedge clk); #1 bus.run = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chki("ticks_60", ticks, 60);
    chki("no_wrap_60", wraps, 0);
    chk24("time_1min", bus.time_bcd, 24'h000100);
    chk1("stopped", bus.running, 1'b0);

    // 24h midnight rollover.
    do_load(24'h235958, 1'b0, 1'b0, 24'h235958, 1'b0);
    tick_run(2, wraps, wrap_at);
    chki("wrap24_cnt", wraps, 1);
    chki("wrap24_at", wrap_at, 2);
    chk24("wrap24_time", bus.time_bcd, 24'h000000);

    // 12h transitions.
    set_mode(1'b1);
    do_load(24'h115959, 1'b0, 1'b0, 24'h115959, 1'b0);
    tick_run(1, wraps, wrap_at);
    chk24("noon_time", bus.time_bcd, 24'h120000);
    chk1("noon_pm", bus.pm, 1'b1);
    chki("noon_nowrap", wraps, 0);
    do_load(24'h125959, 1'b1, 1'b0, 24'h125959, 1'b1);
    tick_run(1, wraps, wrap_at);
    chk24("one_pm_time", bus.time_bcd, 24'h010000);
    chk1("one_pm_pm", bus.pm, 1'b1);
    chki("one_pm_nowrap", wraps, 0);
    do_load(24'h115959, 1'b1, 1'b0, 24'h115959, 1'b1);
    tick_run(1, wraps, wrap_at);
    chk24("mid12_time", bus.time_bcd, 24'h120000);
    chk1("mid12_pm", bus.pm, 1'b0);
    chki("mid12_wrap", wraps, 1);

    // Load validation table.
    for (int i = 0; i < 12; i++) begin
      if (bus.hour_mode != tbl[i].mode) set_mode(tbl[i].mode);
      do_load(tbl[i].bcd, tbl[i].lpm, tbl[i].err, tbl[i].t, tbl[i].pm);
    end

    // Load arriving in the prescaler's last cycle beats the tick.
    @(posedge clk); #1 bus.run = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    bus.load_valid = 1'b1; bus.load_bcd = 24'h101010; bus.load_pm = 1'b0;
    sbq.push_back('{1'b0, 24'h101010, 1'b0});
    @(negedge clk);
    chk1("load_beats_tick", bus.sec_tick, 1'b0);
    chk1("running_pre_load", bus.running, 1'b1);
    @(posedge clk); #1 bus.load_valid = 1'b0; bus.load_bcd = 24'h000000;
    @(negedge clk);
    chk1("running_in_load", bus.running, 1'b0);
    @(posedge clk);
    found = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.sec_tick) begin found = k; break; end
    end
    chki("tick_after_load", found, TD - 1);
    @(posedge clk); #1 bus.run = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk24("time_after_load_tick", bus.time_bcd, 24'h101011);

`ifdef ALARM_EN
    @(posedge clk); #1;
    bus.alarm_valid = 1'b1; bus.alarm_bcd = 24'h000005; bus.alarm_pm = 1'b0; bus.alarm_arm = 1'b1;
    @(posedge clk); #1 bus.alarm_valid = 1'b0;
    do_load(24'h000005, 1'b0, 1'b0, 24'h000005, 1'b0);
    @(posedge clk);
    chki("alarm_not_on_load", alarm_hits, 0);
    do_load(24'h000000, 1'b0, 1'b0, 24'h000000, 1'b0);
    begin
      int seen;
      logic prev, ok;
      seen = 0; prev = 1'b0; ok = 1'b0;
      @(posedge clk); #1 bus.run = 1'b1;
      for (int c = 0; c < 40 && seen < 6; c++) begin
        @(negedge clk);
        if (bus.alarm_hit) ok = prev && (seen == 5);
        if (bus.sec_tick) seen++;
        prev = bus.sec_tick;
      end
      @(posedge clk); #1 bus.run = 1'b0;
      @(posedge clk);
      chki("alarm_hits", alarm_hits, 1);
      chk1("alarm_timing", ok, 1'b1);
    end
    bus.run = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk1("alarm_rst_hit", bus.alarm_hit, 1'b0);
    chk24("alarm_rst_time", bus.time_bcd, 24'h000000);
    apply_reset();
`endif

    // Asynchronous reset in the middle of counting.
    do_load(24'h123456, 1'b0, 1'b0, 24'h123456, 1'b0);
    @(posedge clk); #1 bus.run = 1'b1;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk24("rst_run_time", bus.time_bcd, 24'h000000);
    chk1("rst_run_running", bus.running, 1'b0);
    chk1("rst_run_tick", bus.sec_tick, 1'b0);
    chk1("rst_run_ready", bus.load_ready, 1'b0);
    apply_reset();

    // Asynchronous reset during the S_LOAD cycle discards the payload.
    @(posedge clk); #1;
    bus.load_valid = 1'b1; bus.load_bcd = 24'h050505;
    @(posedge clk); #1 bus.load_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk1("rst_load_err", bus.load_err, 1'b0);
    chk1("rst_load_ready", bus.load_ready, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk24("rst_load_time", bus.time_bcd, 24'h000000);
    chk1("rst_load_ready_back", bus.load_ready, 1'b1);

    repeat (3) @(posedge clk);
    chki("sb_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
